// File: rtl/avalon_anemo_multi.sv
// Multi-channel anemometer frequency meter with an Avalon-MM slave register interface.
// Define AVALON_ANEMO_IRQ_EN to build the gate-complete irq output and its clear-on-write logic.

module avalon_anemo_multi #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned GATE_CYCLES = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic            read_n,
    input  logic [3:0]      address,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    input  logic [N_CH-1:0] anemo_in
`ifdef AVALON_ANEMO_IRQ_EN
    ,
    output logic            irq
`endif
);

    localparam int unsigned   TW      = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] LAST    = TW'(GATE_CYCLES - 1);
    localparam logic          ST_IDLE = 1'b0;
    localparam logic          ST_RUN  = 1'b1;

    logic [N_CH-1:0]            sync1_q, sync2_q, dly_q, pulse;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, res_q, fin_res;
    logic [N_CH-1:0]            sat_q, res_sat_q, fin_sat, valid_q, data_rd;
    logic [TW-1:0]              timer_q;
    logic                       state_q, continu_q, start_q;
    logic [31:0]                readdata_q, rd_mux;
    logic                       wr_en, rd_en, ctrl_wr, raz, stop;
    logic                       unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & ~read_n;
    assign ctrl_wr      = wr_en && (address == 4'd0);
    assign raz          = ctrl_wr && writedata[0];
    assign stop         = ctrl_wr && !writedata[2];
    assign pulse        = sync2_q & ~dly_q;
    assign unused_wdata = ^writedata[31:3];
    assign readdata     = readdata_q;

    // Value each channel would hold after this cycle's pulse, saturating at all-ones.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if (pulse[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                fin_res[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                fin_res[i] = cnt_q[i];
            end
            fin_sat[i] = sat_q[i] | (pulse[i] && (cnt_q[i] == {CNT_W{1'b1}}));
            data_rd[i] = rd_en && (address == 4'(2 + i));
        end
    end

    always_comb begin
        rd_mux = '0;
        if (address == 4'd0) begin
            rd_mux[1] = continu_q;
            rd_mux[2] = start_q;
        end else if (address == 4'd1) begin
            rd_mux[N_CH-1:0] = valid_q;
            rd_mux[31]       = (state_q == ST_RUN);
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (address == 4'(2 + i)) begin
                    rd_mux[CNT_W-1:0] = res_q[i];
                    rd_mux[30]        = res_sat_q[i];
                    rd_mux[31]        = valid_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            dly_q      <= '0;
            readdata_q <= '0;
            cnt_q      <= '0;
            sat_q      <= '0;
            res_q      <= '0;
            res_sat_q  <= '0;
            valid_q    <= '0;
            timer_q    <= '0;
            state_q    <= ST_IDLE;
            continu_q  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            sync1_q <= anemo_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            if (rd_en) begin
                readdata_q <= rd_mux;
            end
            if (raz) begin
                cnt_q     <= '0;
                sat_q     <= '0;
                res_q     <= '0;
                res_sat_q <= '0;
                valid_q   <= '0;
                timer_q   <= '0;
                state_q   <= ST_IDLE;
                start_q   <= 1'b0;
            end else begin
                // Read-clear first so a completion in the same cycle sets valid again.
                valid_q <= valid_q & ~data_rd;
                if (ctrl_wr) begin
                    continu_q <= writedata[1];
                    start_q   <= writedata[2];
                end
                if (state_q == ST_IDLE) begin
                    timer_q <= '0;
                    cnt_q   <= '0;
                    sat_q   <= '0;
                    if (start_q) begin
                        state_q <= ST_RUN;
                    end
                end else if (timer_q == LAST) begin
                    res_q     <= fin_res;
                    res_sat_q <= fin_sat;
                    valid_q   <= '1;
                    timer_q   <= '0;
                    cnt_q     <= '0;
                    sat_q     <= '0;
                    if (!continu_q && !ctrl_wr) begin
                        start_q <= 1'b0;
                    end
                    if (!continu_q || stop) begin
                        state_q <= ST_IDLE;
                    end
                end else if (stop) begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                    cnt_q   <= '0;
                    sat_q   <= '0;
                end else begin
                    timer_q <= timer_q + TW'(1);
                    cnt_q   <= fin_res;
                    sat_q   <= fin_sat;
                end
            end
        end
    end

`ifdef AVALON_ANEMO_IRQ_EN
    logic irq_q, done, status_wr;

    assign done      = (state_q == ST_RUN) && (timer_q == LAST) && !raz;
    assign status_wr = wr_en && (address == 4'd1);
    assign irq       = irq_q;

    // Completion has priority over a simultaneous status write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (raz) begin
            irq_q <= 1'b0;
        end else if (done) begin
            irq_q <= 1'b1;
        end else if (status_wr) begin
            irq_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_anemo_multi.sv
// Scoreboard bench for avalon_anemo_multi (N_CH=2, CNT_W=4, GATE_CYCLES=100).
// Reads push their expected word; a monitor compares readdata one clock later.

module tb_avalon_anemo_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [3:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        a0 = 1'b0;
    logic        a1 = 1'b0;
    logic [1:0]  anemo_in;
`ifdef AVALON_ANEMO_IRQ_EN
    logic        irq;
`endif

    assign anemo_in = {a1, a0};

    avalon_anemo_multi #(
        .N_CH        (2),
        .CNT_W       (4),
        .GATE_CYCLES (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .anemo_in   (anemo_in)
`ifdef AVALON_ANEMO_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string nm, input logic [3:0] a, input logic [31:0] e);
        exp_t t;
        t.name = nm;
        t.val  = e;
        exp_q.push_back(t);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic pulses(input int ch, input int n, input int hi, input int lo);
        repeat (n) begin
            if (ch == 0) a0 = 1'b1; else a1 = 1'b1;
            repeat (hi) @(negedge clk);
            if (ch == 0) a0 = 1'b0; else a1 = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic chk_irq(input string nm, input logic e);
`ifdef AVALON_ANEMO_IRQ_EN
        chk(nm, {31'd0, irq}, {31'd0, e});
`endif
    endtask

    // Monitor: a read sampled at a posedge is checked at the following negedge.
    initial begin
        exp_t t;
        forever begin
            @(posedge clk);
            if (chipselect === 1'b1 && read_n === 1'b0) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: got read 0x%08h with no expected entry", readdata);
                end else begin
                    t = exp_q.pop_front();
                    chk(t.name, readdata, t.val);
                end
            end
        end
    end

    initial begin
        // Reset state
        idle(3);
        chk("reset_readdata", readdata, 32'h0);
        chk_irq("reset_irq", 1'b0);
        reset = 1'b0;
        idle(2);
        wr(4'd4, 32'hFFFF_FFFF);
        wr(4'd1, 32'hFFFF_FFFF);
        rd("rst_status", 4'd1, 32'h0000_0000);
        rd("rst_ctrl",   4'd0, 32'h0000_0000);
        rd("rst_data0",  4'd2, 32'h0000_0000);
        rd("rst_data1",  4'd3, 32'h0000_0000);
        rd("unmapped4",  4'd4, 32'h0000_0000);
        rd("unmapped15", 4'd15, 32'h0000_0000);

        // Single-shot: 10 edges on ch0, 3 on ch1
        wr(4'd0, 32'h4);
        fork
            pulses(0, 10, 2, 2);
            pulses(1, 3, 3, 3);
            idle(110);
        join
        rd("ss_status", 4'd1, 32'h0000_0003);
        rd("ss_ctrl",   4'd0, 32'h0000_0000);
        rd("ss_data0",  4'd2, 32'h8000_000A);
        rd("ss_data1",  4'd3, 32'h8000_0003);
        rd("ss_data0b", 4'd2, 32'h0000_000A);
        rd("ss_status2", 4'd1, 32'h0000_0000);
        chk_irq("ss_irq_set", 1'b1);
        wr(4'd1, 32'h0);
        chk_irq("ss_irq_clr", 1'b0);

        // Continuous: ch0 period 10, three windows, then abort mid-window
        wr(4'd0, 32'h6);
        fork
            pulses(0, 35, 5, 5);
            begin
                idle(105);
                rd("c1_status", 4'd1, 32'h8000_0003);
                rd("c1_data0",  4'd2, 32'h8000_000A);
                rd("c1_data1",  4'd3, 32'h8000_0000);
                rd("c1_status2", 4'd1, 32'h8000_0000);
                idle(95);
                rd("c2_status", 4'd1, 32'h8000_0003);
                rd("c2_data0",  4'd2, 32'h8000_000A);
                rd("c2_data1",  4'd3, 32'h8000_0000);
                rd("c2_status2", 4'd1, 32'h8000_0000);
                idle(96);
                rd("c3_status", 4'd1, 32'h8000_0003);
                rd("c3_data0",  4'd2, 32'h8000_000A);
                rd("c3_data1",  4'd3, 32'h8000_0000);
                rd("c3_status2", 4'd1, 32'h8000_0000);
            end
        join
        wr(4'd0, 32'h2);
        rd("abort_status", 4'd1, 32'h0000_0000);
        rd("abort_data0",  4'd2, 32'h0000_000A);

        // Saturation: 20 edges into a 4-bit counter, then 5 edges
        wr(4'd0, 32'h4);
        fork
            pulses(0, 20, 2, 2);
            idle(110);
        join
        rd("sat_data0", 4'd2, 32'hC000_000F);
        wr(4'd0, 32'h4);
        fork
            pulses(0, 5, 2, 2);
            idle(110);
        join
        rd("sat2_data0", 4'd2, 32'h8000_0005);
        wr(4'd1, 32'h0);

        // Boundary: ch0 edge on the last gate cycle, ch1 edge on the next
        wr(4'd0, 32'h6);
        idle(98);
        a0 = 1'b1;
        idle(1);
        a1 = 1'b1;
        idle(1);
        chk_irq("bnd_irq_pre", 1'b0);
        rd("bnd_rd_on_done", 4'd2, 32'h0000_0005);
        chk_irq("bnd_irq_rise", 1'b1);
        a0 = 1'b0;
        rd("bnd_status", 4'd1, 32'h8000_0003);
        a1 = 1'b0;
        rd("bnd_w1_data0", 4'd2, 32'h8000_0001);
        rd("bnd_w1_data1", 4'd3, 32'h8000_0000);
        idle(96);
        wr(4'd1, 32'h0);
        chk_irq("irq_set_wins", 1'b1);
        rd("bnd_w2_data0", 4'd2, 32'h8000_0000);
        rd("bnd_w2_data1", 4'd3, 32'h8000_0001);
        wr(4'd1, 32'h0);
        chk_irq("irq_wr_clear", 1'b0);

        // raz mid-window
        wr(4'd0, 32'h1);
        rd("raz_status", 4'd1, 32'h0000_0000);
        rd("raz_data0",  4'd2, 32'h0000_0000);
        rd("raz_data1",  4'd3, 32'h0000_0000);
        rd("raz_ctrl",   4'd0, 32'h0000_0002);

        // Asynchronous reset mid-window
        wr(4'd0, 32'h6);
        fork
            pulses(0, 12, 5, 5);
            idle(130);
        join
        rd("pre_rst_ctrl", 4'd0, 32'h0000_0006);
        #2 reset = 1'b1;
        #1;
        chk("arst_readdata", readdata, 32'h0);
        chk_irq("arst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        rd("arst_status", 4'd1, 32'h0000_0000);
        rd("arst_ctrl",   4'd0, 32'h0000_0000);
        rd("arst_data0",  4'd2, 32'h0000_0000);

        idle(3);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
